// File: rtl/year_counter_bcd.sv
// Parametrised BCD year counter with validated load, century/wrap pulses and leap-year flag.
// Optional down-counting is enabled by defining YEAR_DOWN_EN.
module year_counter_bcd #(
  parameter int DIGITS     = 4,
  parameter int RESET_YEAR = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_yr,
  input  logic                  dn,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   ld_year,
  output logic [4*DIGITS-1:0]   year,
  output logic                  leap_year,
  output logic                  century_tick,
  output logic                  wrap,
  output logic                  ld_err
);
  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int y);
    logic [W-1:0] r;
    int v;
    r = '0;
    v = y;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // tens parity plus units digit decides divisibility by 4
  function automatic logic div4(input logic [3:0] t, input logic [3:0] u);
    return (!t[0] && (u == 4'd0 || u == 4'd4 || u == 4'd8)) ||
           ( t[0] && (u == 4'd2 || u == 4'd6));
  endfunction

  localparam logic [W-1:0] RESET_BCD = to_bcd(RESET_YEAR);

  logic [W-1:0] year_q, year_d;
  logic         century_tick_q, century_tick_d;
  logic         wrap_q, wrap_d;
  logic         ld_err_q, ld_err_d;

  logic [W-1:0] inc_year, dec_year;
  logic         ld_ok, carry, borrow, down_step;

`ifdef YEAR_DOWN_EN
  assign down_step = dn;
`else
  logic unused_dn;
  assign unused_dn = dn;
  assign down_step = 1'b0;
`endif

  always_comb begin
    ld_ok    = 1'b1;
    inc_year = year_q;
    dec_year = year_q;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ld_year[4*k +: 4] > 4'd9) ld_ok = 1'b0;
      if (carry) begin
        if (year_q[4*k +: 4] == 4'd9) inc_year[4*k +: 4] = 4'd0;
        else begin
          inc_year[4*k +: 4] = year_q[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (year_q[4*k +: 4] == 4'd0) dec_year[4*k +: 4] = 4'd9;
        else begin
          dec_year[4*k +: 4] = year_q[4*k +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    year_d         = year_q;
    century_tick_d = 1'b0;
    wrap_d         = 1'b0;
    ld_err_d       = 1'b0;
    if (ld) begin
      if (ld_ok) year_d = ld_year;
      else       ld_err_d = 1'b1;
    end else if (en_yr) begin
      if (down_step) begin
        year_d         = dec_year;
        century_tick_d = (year_q[7:0] == 8'h00);
        wrap_d         = borrow;
      end else begin
        year_d         = inc_year;
        century_tick_d = (year_q[7:0] == 8'h99);
        wrap_d         = carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      year_q         <= RESET_BCD;
      century_tick_q <= 1'b0;
      wrap_q         <= 1'b0;
      ld_err_q       <= 1'b0;
    end else begin
      year_q         <= year_d;
      century_tick_q <= century_tick_d;
      wrap_q         <= wrap_d;
      ld_err_q       <= ld_err_d;
    end
  end

  logic div100, div400;
  assign div100    = (year_q[7:4] == 4'd0) && (year_q[3:0] == 4'd0);
  assign div400    = div100 && div4(year_q[15:12], year_q[11:8]);
  assign leap_year = div4(year_q[7:4], year_q[3:0]) && (!div100 || div400);

  assign year         = year_q;
  assign century_tick = century_tick_q;
  assign wrap         = wrap_q;
  assign ld_err       = ld_err_q;
endmodule
